// File: rtl/pair_triple_window.sv
// Sliding 3-bit window feeder for the pair/triple detector, plus a saturating
// tally of valid windows on which the detector reported a hit.
module pair_triple_window #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_val,
   input  logic                 bit_in,
   input  logic                 clear,
   output logic                 win0,
   output logic                 win1,
   output logic                 win2,
   output logic                 win_val,
   input  logic                 det_in,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic                 hit_sat
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      FULL  = 2'd3
   } fill_state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

   fill_state_e          state_q, state_d;
   logic [2:0]           win_q, win_d;
   logic                 win_val_q, win_val_d;
   logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
   logic                 hit_sat_q, hit_sat_d;
   logic                 hit_inc_s;

   // Window shift, fill tracking and window-valid pulse; clear beats a shift.
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      win_val_d = 1'b0;
      if (clear) begin
         state_d = EMPTY;
         win_d   = 3'b000;
      end else if (bit_val) begin
         win_d = {win_q[1:0], bit_in};
         case (state_q)
            EMPTY:   state_d = ONE;
            ONE:     state_d = TWO;
            TWO:     state_d = FULL;
            FULL:    state_d = FULL;
            default: state_d = EMPTY;
         endcase
         win_val_d = (state_d == FULL);
      end else begin
         state_d = state_q;
         win_d   = win_q;
      end
   end

   // A hit counts on the registered window, so clear in the same cycle does not lose it.
   always_comb begin
      hit_inc_s = win_val_q & det_in & (hit_count_q != CNT_MAX);
      if (hit_inc_s) begin
         hit_count_d = hit_count_q + CNT_ONE;
      end else begin
         hit_count_d = hit_count_q;
      end
      hit_sat_d = (hit_count_d == CNT_MAX);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         win_q       <= 3'b000;
         win_val_q   <= 1'b0;
         hit_count_q <= CNT_ZERO;
         hit_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         win_val_q   <= win_val_d;
         hit_count_q <= hit_count_d;
         hit_sat_q   <= hit_sat_d;
      end
   end

   assign win0      = win_q[0];
   assign win1      = win_q[1];
   assign win2      = win_q[2];
   assign win_val   = win_val_q;
   assign hit_count = hit_count_q;
   assign hit_sat   = hit_sat_q;

endmodule

// File: tb/tb_pair_triple_window.sv
// Directed bench: an 8-bit and a 2-bit counter instance share one stimulus
// stream, each fed by a majority-detector model on its own window.
module tb_pair_triple_window;

   logic       clk;
   logic       rst;
   logic       bit_val;
   logic       bit_in;
   logic       clear;

   logic       a_win0, a_win1, a_win2, a_win_val, a_det, a_hit_sat;
   logic [7:0] a_hit_count;
   logic       b_win0, b_win1, b_win2, b_win_val, b_det, b_hit_sat;
   logic [1:0] b_hit_count;

   int checks = 0;
   int errors = 0;

   assign a_det = (a_win0 & a_win1) | ((a_win0 | a_win1) & a_win2);
   assign b_det = (b_win0 & b_win1) | ((b_win0 | b_win1) & b_win2);

   pair_triple_window #(.CNT_WIDTH(8)) u_a (
      .clk(clk), .rst(rst), .bit_val(bit_val), .bit_in(bit_in), .clear(clear),
      .win0(a_win0), .win1(a_win1), .win2(a_win2), .win_val(a_win_val),
      .det_in(a_det), .hit_count(a_hit_count), .hit_sat(a_hit_sat)
   );

   pair_triple_window #(.CNT_WIDTH(2)) u_b (
      .clk(clk), .rst(rst), .bit_val(bit_val), .bit_in(bit_in), .clear(clear),
      .win0(b_win0), .win1(b_win1), .win2(b_win2), .win_val(b_win_val),
      .det_in(b_det), .hit_count(b_hit_count), .hit_sat(b_hit_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic b, input logic c);
      rst     = r;
      bit_val = v;
      bit_in  = b;
      clear   = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] win_a();
      return {29'd0, a_win2, a_win1, a_win0};
   endfunction

   initial begin
      rst = 1'b1; bit_val = 1'b0; bit_in = 1'b0; clear = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_win",     win_a(),               32'd0);
      chk("rst_win_val", 32'(a_win_val),        32'd0);
      chk("rst_hit",     32'(a_hit_count),      32'd0);
      chk("rst_sat",     32'(a_hit_sat),        32'd0);
      chk("rst_hit_b",   32'(b_hit_count),      32'd0);

      // Fill with 1,1,0
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("fill1_val",   32'(a_win_val),        32'd0);
      chk("fill1_win",   win_a(),               32'b001);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("fill2_val",   32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("fill3_win",   win_a(),               32'b110);
      chk("fill3_val",   32'(a_win_val),        32'd1);
      chk("fill3_det",   32'(a_det),            32'd1);
      chk("fill3_hit",   32'(a_hit_count),      32'd0);

      // Gaps and sliding windows
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle1_val",   32'(a_win_val),        32'd0);
      chk("idle1_hit",   32'(a_hit_count),      32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle2_val",   32'(a_win_val),        32'd0);
      chk("idle2_hold",  win_a(),               32'b110);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("slide1_win",  win_a(),               32'b100);
      chk("slide1_val",  32'(a_win_val),        32'd1);
      chk("slide1_det",  32'(a_det),            32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle3_val",   32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("slide2_win",  win_a(),               32'b000);
      chk("slide2_val",  32'(a_win_val),        32'd1);
      chk("slide2_det",  32'(a_det),            32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_hit",     32'(a_hit_count),      32'd1);
      chk("gap_hit_b",   32'(b_hit_count),      32'd1);

      // Saturation on the 2-bit instance: seven 1s give five hitting windows
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst2_hit",    32'(a_hit_count),      32'd0);
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         chk($sformatf("sat_val_%0d", i), 32'(a_win_val), (i >= 3) ? 32'd1 : 32'd0);
         chk($sformatf("sat_a_%0d", i), 32'(a_hit_count), (i > 3) ? 32'(i - 3) : 32'd0);
         chk($sformatf("sat_b_%0d", i), 32'(b_hit_count),
             (i > 6) ? 32'd3 : ((i > 3) ? 32'(i - 3) : 32'd0));
         chk($sformatf("sat_flag_%0d", i), 32'(b_hit_sat), (i >= 6) ? 32'd1 : 32'd0);
      end

      // Clear on a valid hit: hit still counted, window flushed
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("clrhit_a",    32'(a_hit_count),      32'd5);
      chk("clrhit_b",    32'(b_hit_count),      32'd3);
      chk("clrhit_bsat", 32'(b_hit_sat),        32'd1);
      chk("clrhit_asat", 32'(a_hit_sat),        32'd0);
      chk("clrhit_win",  win_a(),               32'd0);
      chk("clrhit_val",  32'(a_win_val),        32'd0);

      // Clear mid-fill with a concurrent bit
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("mid_pre_win", win_a(),               32'b011);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("midclr_win",  win_a(),               32'd0);
      chk("midclr_val",  32'(a_win_val),        32'd0);
      chk("midclr_hit",  32'(a_hit_count),      32'd5);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("refill1_val", 32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("refill2_val", 32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("refill3_val", 32'(a_win_val),        32'd1);
      chk("refill3_win", win_a(),               32'b111);
      chk("refill3_hit", 32'(a_hit_count),      32'd5);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("refill_hit",  32'(a_hit_count),      32'd6);

      // Reset with a pending hit and a concurrent bit
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("prerst_val",  32'(a_win_val),        32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("midrst_win",  win_a(),               32'd0);
      chk("midrst_val",  32'(a_win_val),        32'd0);
      chk("midrst_hit",  32'(a_hit_count),      32'd0);
      chk("midrst_bsat", 32'(b_hit_sat),        32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("post1_win",   win_a(),               32'b001);
      chk("post1_val",   32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("post2_val",   32'(a_win_val),        32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("post3_val",   32'(a_win_val),        32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_hit",    32'(a_hit_count),      32'd1);
      chk("post_val",    32'(a_win_val),        32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
